// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and state encoding for the CORDIC rotator.
//   ANGLE_W  datapath width (Q2.16, two's complement)
//   FRAC_W   fractional bits
//   K_INIT   CORDIC gain compensation, preloaded into x so no final scaling is needed
//   HALF_PI  pi/2 in Q2.16, the legal angle bound
package cordic_pkg;
    localparam int ANGLE_W = 18;
    localparam int FRAC_W  = 16;
    localparam int IDX_W   = 5;

    localparam logic signed [ANGLE_W-1:0] K_INIT  = 18'sd39797;
    localparam logic signed [ANGLE_W-1:0] HALF_PI = 18'sd102944;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/cordic_rotator_if.sv
// cordic_rotator_if: request/result bus plus the arctan table lookup pair.
//   start, angle_in      request from the controller
//   angle_idx/angle_val  table index out, table angle back (same cycle)
//   cos_out, sin_out     held results
//   busy, done           status; done is a one-cycle completion pulse
// master: requester + table side.  slave: the rotator engine.
interface cordic_rotator_if
    import cordic_pkg::*;
    ();
    logic                      start;
    logic signed [ANGLE_W-1:0] angle_in;
    logic [IDX_W-1:0]          angle_idx;
    logic signed [ANGLE_W-1:0] angle_val;
    logic signed [ANGLE_W-1:0] cos_out;
    logic signed [ANGLE_W-1:0] sin_out;
    logic                      busy;
    logic                      done;

    modport master (
        output start, angle_in, angle_val,
        input  angle_idx, cos_out, sin_out, busy, done
    );

    modport slave (
        input  start, angle_in, angle_val,
        output angle_idx, cos_out, sin_out, busy, done
    );
endinterface

// File: rtl/cordic_stage.sv
// cordic_stage: one combinational rotation-mode micro-rotation.
//   x, y, z    current vector and residual angle
//   i          iteration index (shift amount)
//   angle_val  atan(2^-i) in Q2.16
//   x_next, y_next, z_next  rotated vector and updated residual
// Direction follows the sign of z; zero counts as positive.
// All arithmetic wraps at 18 bits; shifts are arithmetic (floor).
module cordic_stage
    import cordic_pkg::*;
(
    input  logic signed [ANGLE_W-1:0] x,
    input  logic signed [ANGLE_W-1:0] y,
    input  logic signed [ANGLE_W-1:0] z,
    input  logic        [IDX_W-1:0]   i,
    input  logic signed [ANGLE_W-1:0] angle_val,
    output logic signed [ANGLE_W-1:0] x_next,
    output logic signed [ANGLE_W-1:0] y_next,
    output logic signed [ANGLE_W-1:0] z_next
);
    logic signed [ANGLE_W-1:0] x_sh;
    logic signed [ANGLE_W-1:0] y_sh;

    assign x_sh = x >>> i;
    assign y_sh = y >>> i;

    always_comb begin
        x_next = x;
        y_next = y;
        z_next = z;
        if (!z[ANGLE_W-1]) begin
            x_next = x - y_sh;
            y_next = y + x_sh;
            z_next = z - angle_val;
        end else begin
            x_next = x + y_sh;
            y_next = y - x_sh;
            z_next = z + angle_val;
        end
    end
endmodule

// File: rtl/cordic_rotator.sv
// cordic_rotator: iterative rotation-mode CORDIC, angle -> (cos, sin).
//   clk, rst  rising-edge clock, asynchronous active-high reset
//   bus       cordic_rotator_if.slave (request, table lookup, results)
// One micro-rotation per cycle through a single reused cordic_stage.
// Latency start->done is ITERATIONS+1 cycles.
// Build option: CORDIC_CLAMP_EN clamps angle_in to +/-HALF_PI when loaded;
// without it the angle is loaded as given.
module cordic_rotator
    import cordic_pkg::*;
#(
    parameter int ITERATIONS = 16
) (
    input logic              clk,
    input logic              rst,
    cordic_rotator_if.slave  bus
);
    state_t                    state;
    logic [IDX_W-1:0]          i;
    logic signed [ANGLE_W-1:0] x, y, z;
    logic signed [ANGLE_W-1:0] x_n, y_n, z_n;
    logic signed [ANGLE_W-1:0] z_load;
    logic signed [ANGLE_W-1:0] cos_r, sin_r;
    logic                      busy_r, done_r;

    always_comb begin
        z_load = bus.angle_in;
`ifdef CORDIC_CLAMP_EN
        if (bus.angle_in > HALF_PI)
            z_load = HALF_PI;
        else if (bus.angle_in < -HALF_PI)
            z_load = -HALF_PI;
`endif
    end

    cordic_stage u_stage (
        .x         (x),
        .y         (y),
        .z         (z),
        .i         (i),
        .angle_val (bus.angle_val),
        .x_next    (x_n),
        .y_next    (y_n),
        .z_next    (z_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            i      <= '0;
            x      <= '0;
            y      <= '0;
            z      <= '0;
            cos_r  <= '0;
            sin_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    // done is still high in the first IDLE cycle; a start
                    // there belongs to the finished request and is dropped.
                    if (bus.start && !done_r) begin
                        x      <= K_INIT;
                        y      <= '0;
                        z      <= z_load;
                        i      <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    x <= x_n;
                    y <= y_n;
                    z <= z_n;
                    if (i == IDX_W'(ITERATIONS - 1)) begin
                        // i returns to 0 so angle_idx reads 0 outside RUN.
                        i      <= '0;
                        busy_r <= 1'b0;
                        state  <= DONE;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                DONE: begin
                    cos_r  <= x;
                    sin_r  <= y;
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.angle_idx = i;
    assign bus.cos_out   = cos_r;
    assign bus.sin_out   = sin_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
endmodule

// File: tb/tb_cordic_rotator.sv
module tb_cordic_rotator;
    localparam int N      = 16;
    localparam int TOL    = 8;
    localparam int RTOL   = 24;
    localparam real SCALE = 65536.0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   atan_tab [0:17];

    cordic_rotator_if bus ();

    cordic_rotator #(.ITERATIONS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // arctan table model: atan(2^-i) rounded to Q2.16
    initial begin
        for (int k = 0; k < 18; k++)
            atan_tab[k] = $rtoi($atan(1.0 / (2.0 ** k)) * SCALE + 0.5);
    end

    always_comb begin
        if (bus.angle_idx < 5'd18)
            bus.angle_val = 18'(atan_tab[bus.angle_idx]);
        else
            bus.angle_val = '0;
    end

    typedef struct {
        int angle;
        int ecos;
        int esin;
    } vec_t;

    task automatic check(input string name, input int act, input int exp, input int tol);
        int diff;
        checks++;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    // Issue one request and follow it to completion. bad counts protocol
    // deviations: idx sequence, busy window, done pulse width, and a start
    // raised in the done cycle that must be ignored.
    task automatic run_conv(input int ang, output int c, output int s,
                            output int lat, output int bad);
        lat = -1;
        bad = 0;
        c   = 0;
        s   = 0;
        @(posedge clk); #1;
        bus.angle_in = 18'(ang);
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (bus.angle_idx !== 5'd0 || bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k < N) begin
                if (bus.angle_idx !== 5'(k) || bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
            end else if (k == N) begin
                if (bus.angle_idx !== 5'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
            end
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        c = int'(bus.cos_out);
        s = int'(bus.sin_out);
        if (lat > 0) begin
            if (bus.busy !== 1'b0) bad++;
            bus.angle_in = 18'd0;
            bus.start    = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
    endtask

    initial begin
        vec_t vecs [5];
        int   c, s, lat, bad, ndone;
        int   ang;
        real  rad;

        vecs[0] = '{angle: 0,       ecos: 65536, esin: 0};
        vecs[1] = '{angle: 51472,   ecos: 46341, esin: 46341};
        vecs[2] = '{angle: -102944, ecos: 0,     esin: -65536};
        vecs[3] = '{angle: 102944,  ecos: 0,     esin: 65536};
        vecs[4] = '{angle: 25736,   ecos: 60547, esin: 25080};

        bus.start    = 1'b0;
        bus.angle_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(bus.busy), 0, 0);
        check("rst_done", int'(bus.done), 0, 0);
        check("rst_cos", int'(bus.cos_out), 0, 0);
        check("rst_sin", int'(bus.sin_out), 0, 0);
        check("rst_idx", int'(bus.angle_idx), 0, 0);
        rst = 1'b0;

        // table vectors
        foreach (vecs[v]) begin
            run_conv(vecs[v].angle, c, s, lat, bad);
            check($sformatf("vec%0d_latency", v), lat, N + 1, 0);
            check($sformatf("vec%0d_protocol", v), bad, 0, 0);
            check($sformatf("vec%0d_cos", v), c, vecs[v].ecos, TOL);
            check($sformatf("vec%0d_sin", v), s, vecs[v].esin, TOL);
        end

        // second start mid-conversion is ignored
        @(posedge clk); #1;
        bus.angle_in = 18'(51472);
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin
                bus.angle_in = 18'(-51472);
                bus.start    = 1'b1;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done === 1'b1) ndone++;
        end
        check("restart_done_count", ndone, 1, 0);
        check("restart_cos", int'(bus.cos_out), 46341, TOL);
        check("restart_sin", int'(bus.sin_out), 46341, TOL);

        // reset mid-RUN
        @(posedge clk); #1;
        bus.angle_in = 18'd0;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(bus.busy), 0, 0);
        check("midrst_done", int'(bus.done), 0, 0);
        check("midrst_cos", int'(bus.cos_out), 0, 0);
        check("midrst_sin", int'(bus.sin_out), 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
        end
        check("midrst_no_activity", ndone, 0, 0);
        run_conv(-51472, c, s, lat, bad);
        check("postrst_latency", lat, N + 1, 0);
        check("postrst_protocol", bad, 0, 0);
        check("postrst_cos", c, 46341, TOL);
        check("postrst_sin", s, -46341, TOL);

`ifdef CORDIC_CLAMP_EN
        run_conv(131071, c, s, lat, bad);
        check("clamp_pos_cos", c, 0, TOL);
        check("clamp_pos_sin", s, 65536, TOL);
        run_conv(-131072, c, s, lat, bad);
        check("clamp_neg_cos", c, 0, TOL);
        check("clamp_neg_sin", s, -65536, TOL);
`endif

        // random angles against real-valued trig
        for (int r = 0; r < 20; r++) begin
            ang = int'($urandom_range(205888)) - 102944;
            rad = real'(ang) / SCALE;
            run_conv(ang, c, s, lat, bad);
            check($sformatf("rnd%0d_latency", r), lat, N + 1, 0);
            check($sformatf("rnd%0d_protocol", r), bad, 0, 0);
            check($sformatf("rnd%0d_cos a=%0d", r, ang), c, $rtoi($floor($cos(rad) * SCALE + 0.5)), RTOL);
            check($sformatf("rnd%0d_sin a=%0d", r, ang), s, $rtoi($floor($sin(rad) * SCALE + 0.5)), RTOL);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
